// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV unit with HI/LO registers.
// Uses one multi-cycle shift-add or restoring-divide datapath, with sign correction in DONE.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hiloen,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             is_div, neg_q, neg_r, divzero;
  logic [WIDTH-1:0] opnd, raw_a, pl;
  logic [WIDTH:0]   ph;
  logic [CW-1:0]    cnt;

  logic             start;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, mul_ph, div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_ge;
  logic [WIDTH:0]   ph_next;
  logic [WIDTH-1:0] pl_next;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign start = hiloen && (state == IDLE) &&
                 ((alucontrol == 4'b1000) || (alucontrol == 4'b1001));
  assign abs_a = srca[WIDTH-1] ? -srca : srca;
  assign abs_b = srcb[WIDTH-1] ? -srcb : srcb;

  // ph/pl are shared: {product high, multiplier} for MULT, {remainder, dividend->quotient} for DIV.
  always_comb begin
    mul_sum   = ph + {1'b0, opnd};
    mul_ph    = pl[0] ? mul_sum : ph;
    div_shift = {ph[WIDTH-1:0], pl[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd};
    div_ge    = ~div_trial[WIDTH+1];
    if (is_div) begin
      ph_next = div_ge ? div_trial[WIDTH:0] : div_shift;
      pl_next = {pl[WIDTH-2:0], div_ge};
    end else begin
      ph_next = {1'b0, mul_ph[WIDTH:1]};
      pl_next = {mul_ph[0], pl[WIDTH-1:1]};
    end
    prod     = {ph[WIDTH-1:0], pl};
    prod_fix = neg_q ? -prod : prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divzero <= 1'b0;
      opnd    <= '0;
      raw_a   <= '0;
      ph      <= '0;
      pl      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= alucontrol[0];
            neg_q   <= srca[WIDTH-1] ^ srcb[WIDTH-1];
            neg_r   <= srca[WIDTH-1];
            divzero <= (srcb == '0);
            raw_a   <= srca;
            opnd    <= alucontrol[0] ? abs_b : abs_a;
            pl      <= alucontrol[0] ? abs_a : abs_b;
            ph      <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          ph  <= ph_next;
          pl  <= pl_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (divzero) begin
            hi <= raw_a;
            lo <= '1;
          end else begin
            hi <= neg_r ? -ph[WIDTH-1:0] : ph[WIDTH-1:0];
            lo <= neg_q ? -pl : pl;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign hilo_out = (alucontrol == 4'b1010) ? hi : lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, busy length, ignored starts, async reset.
module tb_muldiv_unit;
  localparam int unsigned W = 32;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  logic         clk = 1'b0;
  logic         reset;
  logic         hiloen;
  logic [3:0]   alucontrol;
  logic [W-1:0] srca, srcb;
  logic         busy;
  logic [W-1:0] hilo_out, hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .hiloen(hiloen), .alucontrol(alucontrol),
    .srca(srca), .srcb(srcb), .busy(busy), .hilo_out(hilo_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    hiloen = 1'b1; alucontrol = op; srca = a; srcb = b;
    @(posedge clk);
    #1 hiloen = 1'b0; alucontrol = 4'b0000;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic run_case(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
    int c;
    start_op(op, a, b);
    wait_idle(c);
    check({tag, " busy_cycles"}, W'(c), 32'd33);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1; hiloen = 1'b0; alucontrol = 4'b0000; srca = '0; srcb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset hilo_out", hilo_out, 32'h0);
    @(negedge clk) reset = 1'b0;

    // hiloen with a non-MULT/DIV code must not start anything
    @(negedge clk);
    hiloen = 1'b1; alucontrol = OP_MFHI; srca = 32'd5; srcb = 32'd5;
    @(posedge clk);
    #1 hiloen = 1'b0;
    check("nostart busy", {31'b0, busy}, 32'd0);

    run_case("mult 7x-3", OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_case("mult max", OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
    alucontrol = OP_MFHI; #1;
    check("mfhi", hilo_out, 32'h3FFFFFFF);
    alucontrol = OP_MFLO; #1;
    check("mflo", hilo_out, 32'h00000001);

    run_case("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    alucontrol = OP_MFLO; #1;
    check("mflo div", hilo_out, 32'hFFFFFFFD);
    run_case("div 100/7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);
    run_case("div 100/-7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
    run_case("div 10/0", OP_DIV, 32'd10, 32'd0, 32'h0000000A, 32'hFFFFFFFF);
    run_case("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_case("mult -5x-6", OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'd30);

    // second start at cycle 5 of a MULT must be ignored
    start_op(OP_MULT, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    hiloen = 1'b1; alucontrol = OP_MULT; srca = 32'd100; srcb = 32'd100;
    @(posedge clk);
    #1 hiloen = 1'b0; alucontrol = 4'b0000;
    wait_idle(n);
    check("ignored busy_cycles", W'(n + 5), 32'd33);
    check("ignored hi", hi, 32'h0);
    check("ignored lo", lo, 32'd15);
    repeat (3) @(posedge clk);
    #1 check("ignored stays idle", {31'b0, busy}, 32'd0);

    // async reset mid-MULT
    start_op(OP_MULT, 32'd7, 32'hFFFFFFFD);
    repeat (9) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    check("midreset hilo_out", hilo_out, 32'h0);
    @(negedge clk) reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("postreset busy", {31'b0, busy}, 32'd0);
    check("postreset lo", lo, 32'h0);
    check("postreset hi", hi, 32'h0);

    run_case("mult after reset", OP_MULT, 32'd2, 32'd3, 32'h0, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
